// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned PERF_W              = 32;

  // Wait counter must hold values up to the timeout itself.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous clear.
module hazard_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, branch redirect flush,
// data-memory wait freeze with timeout fault, and performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_flush,
  output logic              err_out,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);

  localparam int unsigned WAIT_W = wait_cnt_width(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              load_use, mem_wait;
  logic              hold, do_redirect, do_lu;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_wait = mem_req && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ST_FAULT) begin
        err_out <= 1'b1;
      end
    end
  end

  // Memory wait outranks redirect, which outranks load-use.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    hold         = 1'b0;
    do_redirect  = 1'b0;
    do_lu        = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;

    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_wait) begin
          hold = 1'b1;
          if (state == ST_RUN) begin
            wait_cnt_nxt = WAIT_W'(1);
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
          if (32'(wait_cnt_nxt) >= MEM_TIMEOUT) begin
            state_nxt = ST_FAULT;
          end else begin
            state_nxt = ST_MEM_WAIT;
          end
        end else begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
          if (ex_redirect) begin
            do_redirect = 1'b1;
          end else if (load_use) begin
            do_lu = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        hold = 1'b1;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // Outputs are quiet for the whole reset cycle.
    if (!rst) begin
      pc_stall     = hold | do_lu;
      if_id_stall  = hold | do_lu;
      id_ex_stall  = hold;
      ex_mem_stall = hold;
      mem_wb_flush = hold;
      if_id_flush  = do_redirect;
      id_ex_flush  = do_redirect | do_lu;
    end
  end

  hazard_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (if_id_flush),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_hazard_ctrl;

  localparam int unsigned TMO = 4;

  localparam logic [6:0] O_NONE = 7'b000_0000;
  localparam logic [6:0] O_LU   = 7'b110_0010;
  localparam logic [6:0] O_RD   = 7'b000_0110;
  localparam logic [6:0] O_HOLD = 7'b111_1001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic        mem_req, mem_ready;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, err_out;
  logic [31:0] stall_cycles, flush_events;
  logic [6:0]  ctl;

  logic        c4_clr, c4_inc;
  logic [3:0]  c4_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_stall  (id_ex_stall),
    .ex_mem_stall (ex_mem_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .mem_wb_flush (mem_wb_flush),
    .err_out      (err_out),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  hazard_perf_cnt #(.W(4)) u_cnt4 (
    .clk   (clk),
    .clr   (c4_clr),
    .inc   (c4_inc),
    .count (c4_cnt)
  );

  assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, mem_wb_flush};

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] exp;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit              m_fault;
  int              m_wait;
  bit              m_err;
  longint unsigned m_sc, m_fe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic ld, input logic redir,
                             input logic req, input logic rdy);
    in_t i;
    i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.rd = rd;
    i.ld = ld; i.redir = redir; i.req = req; i.rdy = rdy;
    return i;
  endfunction

  task automatic apply(input in_t i, input logic r);
    @(negedge clk);
    rst         = r;
    id_rs1      = i.rs1;
    id_rs2      = i.rs2;
    id_uses_rs1 = i.u1;
    id_uses_rs2 = i.u2;
    ex_rd       = i.rd;
    ex_mem_read = i.ld;
    ex_redirect = i.redir;
    mem_req     = i.req;
    mem_ready   = i.rdy;
    #1;
  endtask

  function automatic logic [6:0] m_ctl(input in_t i, input logic r);
    bit lu;
    lu = i.ld && (i.rd != 0) && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
    if (r) return O_NONE;
    if (m_fault || (i.req && !i.rdy)) return O_HOLD;
    if (i.redir) return O_RD;
    if (lu) return O_LU;
    return O_NONE;
  endfunction

  task automatic m_tick(input in_t i, input logic r, input logic [6:0] c);
    if (r) begin
      m_fault = 0; m_wait = 0; m_err = 0; m_sc = 0; m_fe = 0;
    end else begin
      if (c[6] && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (c[2] && m_fe < 64'hFFFF_FFFF) m_fe++;
      if (!m_fault) begin
        if (i.req && !i.rdy) begin
          m_wait++;
          if (m_wait >= int'(TMO)) begin
            m_fault = 1;
            m_err   = 1;
          end
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t        idle, lu5, lu5_rd0, ri;
    vec_t       vt[$];
    logic [6:0] e;
    logic       r;

    idle    = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu5     = mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    lu5_rd0 = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    vt.push_back('{"idle",       idle,                                                        O_NONE});
    vt.push_back('{"lu_rs1",     mk(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), O_LU});
    vt.push_back('{"lu_rs2",     mk(5'd2, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), O_LU});
    vt.push_back('{"rs1_unused", mk(5'd7, 5'd1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), O_NONE});
    vt.push_back('{"no_load",    mk(5'd7, 5'd1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), O_NONE});
    vt.push_back('{"rd_zero",    mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), O_NONE});
    vt.push_back('{"redirect",   mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), O_RD});
    vt.push_back('{"redir_lu",   mk(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0), O_RD});
    vt.push_back('{"req_ready",  mk(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1), O_LU});
    vt.push_back('{"mem_wait",   mk(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0), O_HOLD});
    vt.push_back('{"release",    mk(5'd7, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1), O_RD});
    vt.push_back('{"idle_after", idle,                                                        O_NONE});

    c4_clr = 1'b1;
    c4_inc = 1'b0;

    // Reset, with a live hazard on the inputs during the reset cycle
    apply(idle, 1'b1);
    apply(lu5, 1'b1);
    chk("rst_gate_ctl", 32'(ctl), 32'(O_NONE));
    apply(idle, 1'b0);
    chk("reset_ctl", 32'(ctl), 32'(O_NONE));
    chk("reset_err", 32'(err_out), 32'd0);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    chk("reset_flush_cnt", flush_events, 32'd0);

    // Single load-use bubble
    apply(lu5, 1'b0);
    chk("lu_ctl", 32'(ctl), 32'(O_LU));
    apply(idle, 1'b0);
    chk("lu_release_ctl", 32'(ctl), 32'(O_NONE));
    chk("lu_stall_cnt", stall_cycles, 32'd1);
    apply(lu5_rd0, 1'b0);
    chk("rd0_ctl", 32'(ctl), 32'(O_NONE));
    apply(idle, 1'b0);
    chk("rd0_stall_cnt", stall_cycles, 32'd1);

    // Vector table from a fresh reset
    apply(idle, 1'b1);
    foreach (vt[k]) begin
      apply(vt[k].in, 1'b0);
      chk({"vec_", vt[k].name}, 32'(ctl), 32'(vt[k].exp));
    end

    // Redirect overrides load-use
    apply(idle, 1'b1);
    apply(mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    chk("redir_lu_ctl", 32'(ctl), 32'(O_RD));
    apply(idle, 1'b0);
    chk("redir_flush_cnt", flush_events, 32'd1);
    chk("redir_stall_cnt", stall_cycles, 32'd0);

    // Three-cycle memory wait with a redirect held behind it
    for (int k = 0; k < 3; k++) begin
      apply(mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0), 1'b0);
      chk($sformatf("memwait_hold%0d", k), 32'(ctl), 32'(O_HOLD));
    end
    apply(mk(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1), 1'b0);
    chk("memwait_release_ctl", 32'(ctl), 32'(O_RD));
    apply(idle, 1'b0);
    chk("memwait_after_ctl", 32'(ctl), 32'(O_NONE));
    chk("memwait_stall_cnt", stall_cycles, 32'd3);
    chk("memwait_flush_cnt", flush_events, 32'd2);
    chk("memwait_err", 32'(err_out), 32'd0);

    // Timeout into FAULT, sticky until reset
    for (int k = 0; k < int'(TMO); k++) begin
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
      chk($sformatf("tmo_hold%0d", k), 32'(ctl), 32'(O_HOLD));
      chk($sformatf("tmo_err%0d", k), 32'(err_out), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
      chk($sformatf("fault_ctl%0d", k), 32'(ctl), 32'(O_HOLD));
      chk($sformatf("fault_err%0d", k), 32'(err_out), 32'd1);
    end
    apply(idle, 1'b1);
    chk("fault_rst_ctl", 32'(ctl), 32'(O_NONE));
    apply(idle, 1'b0);
    chk("fault_exit_ctl", 32'(ctl), 32'(O_NONE));
    chk("fault_exit_err", 32'(err_out), 32'd0);
    chk("fault_exit_stall_cnt", stall_cycles, 32'd0);
    chk("fault_exit_flush_cnt", flush_events, 32'd0);

    // Randomized run against the reference model
    for (int k = 0; k < 1500; k++) begin
      ri.rs1   = 5'($urandom_range(0, 3));
      ri.rs2   = 5'($urandom_range(0, 3));
      ri.u1    = 1'($urandom_range(0, 1));
      ri.u2    = 1'($urandom_range(0, 1));
      ri.rd    = 5'($urandom_range(0, 3));
      ri.ld    = ($urandom_range(0, 99) < 40);
      ri.redir = ($urandom_range(0, 99) < 20);
      ri.req   = ($urandom_range(0, 99) < 30);
      ri.rdy   = ($urandom_range(0, 99) < 45);
      r        = (k == 0) || ($urandom_range(0, 99) < 3);
      apply(ri, r);
      e = m_ctl(ri, r);
      chk($sformatf("rnd%0d_ctl", k), 32'(ctl), 32'(e));
      chk($sformatf("rnd%0d_err", k), 32'(err_out), 32'(m_err));
      chk($sformatf("rnd%0d_stall_cnt", k), stall_cycles, 32'(m_sc));
      chk($sformatf("rnd%0d_flush_cnt", k), flush_events, 32'(m_fe));
      m_tick(ri, r, e);
    end

    // Narrow counter saturates and clears
    @(negedge clk);
    c4_clr = 1'b0;
    c4_inc = 1'b1;
    repeat (20) @(negedge clk);
    chk("cnt4_saturate", 32'(c4_cnt), 32'd15);
    c4_clr = 1'b1;
    @(negedge clk);
    chk("cnt4_clear", 32'(c4_cnt), 32'd0);

    // Full-width stall counter held at its maximum
    apply(idle, 1'b1);
    apply(idle, 1'b0);
    @(negedge clk);
    force dut.u_stall_cnt.count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_stall_cnt.count;
    apply(lu5, 1'b0);
    chk("sat_lu_ctl", 32'(ctl), 32'(O_LU));
    chk("sat_pre", stall_cycles, 32'hFFFF_FFFF);
    apply(idle, 1'b0);
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
